// File: rtl/stream_sram_writer.sv
// Byte-stream to 32-bit SRAM word writer.
// Packs incoming bytes little-endian into words. Each full or flushed word is
// written to consecutive word addresses starting at a latched base address.
module stream_sram_writer #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W:0]   cfg_len,
    input  logic              flush,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] sram_address,
    output logic [3:0]        sram_byteenable,
    output logic              sram_chipselect,
    output logic              sram_write,
    output logic [31:0]       sram_writedata,
    output logic              sram_clken,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written
);

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  ww_d;
    logic [1:0]        lane_idx_q, lane_idx_d;
    logic [3:0]        lanes_q, lanes_d;
    logic [31:0]       data_q, data_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       wdata_d;
    logic [3:0]        be_d;
    logic              wr_d;
    logic              accept_c;

    // A byte moves when the registered ready (high only in FILL) meets valid.
    assign accept_c = in_valid && in_ready;

    // Next-state, datapath and next-output computation.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        ww_d       = words_written;
        lane_idx_d = lane_idx_q;
        lanes_d    = lanes_q;
        data_d     = data_q;
        addr_d     = sram_address;
        wdata_d    = sram_writedata;
        be_d       = 4'b0000;
        wr_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ww_d       = '0;
                    lane_idx_d = 2'd0;
                    lanes_d    = 4'b0000;
                    data_d     = 32'h0;
                    if (cfg_len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        base_d  = cfg_base;
                        len_d   = (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
                        state_d = ST_FILL;
                    end
                end
            end

            ST_FILL: begin
                if (accept_c) begin
                    data_d[{lane_idx_q, 3'b000} +: 8] = in_data;
                    lanes_d[lane_idx_q]               = 1'b1;
                    lane_idx_d                        = lane_idx_q + 2'd1;
                end
                // A byte arriving with flush is part of the flushed word.
                if ((accept_c && (lane_idx_q == 2'd3)) || (flush && (lanes_d != 4'b0000))) begin
                    state_d = ST_WRITE;
                    wr_d    = 1'b1;
                    be_d    = lanes_d;
                    wdata_d = data_d;
                    addr_d  = base_q + words_written[ADDR_W-1:0];
                end
            end

            ST_WRITE: begin
                ww_d       = words_written + LEN_W'(1);
                lane_idx_d = 2'd0;
                lanes_d    = 4'b0000;
                data_d     = 32'h0;
                state_d    = (ww_d == len_q) ? ST_DONE : ST_FILL;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs aligned with the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            base_q          <= '0;
            len_q           <= '0;
            lane_idx_q      <= 2'd0;
            lanes_q         <= 4'b0000;
            data_q          <= 32'h0;
            in_ready        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            sram_chipselect <= 1'b0;
            sram_write      <= 1'b0;
            sram_byteenable <= 4'b0000;
            sram_address    <= '0;
            sram_writedata  <= 32'h0;
            sram_clken      <= 1'b1;
            words_written   <= '0;
        end else begin
            state_q         <= state_d;
            base_q          <= base_d;
            len_q           <= len_d;
            lane_idx_q      <= lane_idx_d;
            lanes_q         <= lanes_d;
            data_q          <= data_d;
            in_ready        <= (state_d == ST_FILL);
            busy            <= (state_d != ST_IDLE);
            done            <= (state_d == ST_DONE);
            sram_chipselect <= wr_d;
            sram_write      <= wr_d;
            sram_byteenable <= be_d;
            sram_address    <= addr_d;
            sram_writedata  <= wdata_d;
            sram_clken      <= 1'b1;
            words_written   <= ww_d;
        end
    end

endmodule

// File: tb/tb_stream_sram_writer.sv
// Self-checking bench for stream_sram_writer: directed scenarios plus random
// transfers, checked against a byte-queue reference model.
module tb_stream_sram_writer;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] cfg_base;
    logic [AW:0]   cfg_len;
    logic          flush;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] sram_address;
    logic [3:0]    sram_byteenable;
    logic          sram_chipselect;
    logic          sram_write;
    logic [31:0]   sram_writedata;
    logic          sram_clken;
    logic          busy;
    logic          done;
    logic [AW:0]   words_written;

    stream_sram_writer #(.ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cfg_base(cfg_base),
        .cfg_len(cfg_len), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sram_address(sram_address),
        .sram_byteenable(sram_byteenable), .sram_chipselect(sram_chipselect),
        .sram_write(sram_write), .sram_writedata(sram_writedata),
        .sram_clken(sram_clken), .busy(busy), .done(done),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [3:0]    be;
        logic [31:0]   d;
    } wr_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int viol = 0;
    int done_cnt = 0;
    int done_base = 0;
    int last_wr_cyc = 0;
    int last_done_cyc = 0;
    wr_t got_q[$];
    wr_t exp_q[$];

    // reference model state
    int unsigned m_base, m_len, m_cnt;
    logic [7:0]  m_pend[$];

    always @(posedge clk) cyc <= cyc + 1;

    // bus monitor: collect writes, count done pulses, watch bus rules
    always @(negedge clk) begin
        if (sram_write === 1'b1) begin
            wr_t w;
            w.a = sram_address;
            w.be = sram_byteenable;
            w.d = sram_writedata;
            got_q.push_back(w);
            last_wr_cyc = cyc;
            if (in_ready !== 1'b0 || sram_chipselect !== 1'b1) viol++;
        end else if (sram_chipselect !== 1'b0 || sram_byteenable !== 4'b0000) begin
            viol++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (reset_n && sram_clken !== 1'b1) viol++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " done"}, 64'(done), 64'd0);
        chk({tag, " cs"}, 64'(sram_chipselect), 64'd0);
        chk({tag, " write"}, 64'(sram_write), 64'd0);
        chk({tag, " be"}, 64'(sram_byteenable), 64'd0);
        chk({tag, " addr"}, 64'(sram_address), 64'd0);
        chk({tag, " wdata"}, 64'(sram_writedata), 64'd0);
        chk({tag, " ww"}, 64'(words_written), 64'd0);
        chk({tag, " clken"}, 64'(sram_clken), 64'd1);
    endtask

    task automatic model_emit();
        wr_t w;
        w.d = 32'h0;
        w.be = 4'h0;
        for (int k = 0; k < m_pend.size(); k++) begin
            w.d[8*k +: 8] = m_pend[k];
            w.be[k] = 1'b1;
        end
        w.a = AW'((m_base + m_cnt) % (1 << AW));
        exp_q.push_back(w);
        m_cnt++;
        m_pend.delete();
    endtask

    task automatic start_xfer(input int unsigned base, input int unsigned len);
        @(negedge clk);
        start = 1'b1;
        cfg_base = AW'(base);
        cfg_len = (AW+1)'(len);
        @(negedge clk);
        start = 1'b0;
        m_base = base;
        m_len = (len > (1 << AW)) ? (1 << AW) : len;
        m_cnt = 0;
        m_pend.delete();
        got_q.delete();
        exp_q.delete();
        done_base = done_cnt;
    endtask

    task automatic wait_ready(input string tag);
        int i;
        for (i = 0; i < 50; i++) begin
            if (in_ready === 1'b1) break;
            @(negedge clk);
        end
        if (i == 50) chk({tag, " ready timeout"}, 64'(in_ready), 64'd1);
    endtask

    task automatic put_byte(input logic [7:0] b, input logic fl);
        wait_ready("put_byte");
        in_valid = 1'b1;
        in_data = b;
        flush = fl;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        in_data = 8'($urandom);
        m_pend.push_back(b);
        if (m_pend.size() == 4 || fl) model_emit();
    endtask

    task automatic flush_only();
        wait_ready("flush");
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        if (m_pend.size() > 0) model_emit();
    endtask

    task automatic wait_done(input string tag);
        int i;
        for (i = 0; i < 100; i++) begin
            if (done_cnt > done_base) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        chk({tag, " done pulses"}, 64'(done_cnt - done_base), 64'd1);
        chk({tag, " busy after done"}, 64'(busy), 64'd0);
    endtask

    task automatic check_xfer(input string tag, input int unsigned exp_ww);
        chk({tag, " write count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s write%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        chk({tag, " words_written"}, 64'(words_written), 64'(exp_ww));
        if (exp_q.size() > 0)
            chk({tag, " done latency"}, 64'(last_done_cyc - last_wr_cyc), 64'd1);
    endtask

    initial begin
        logic [7:0] bytes8 [8];
        reset_n = 1'b0;
        start = 1'b0;
        cfg_base = '0;
        cfg_len = '0;
        flush = 1'b0;
        in_data = 8'h0;
        in_valid = 1'b0;
        #12;
        chk_reset_state("rst0");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // two full words at base 0x010
        bytes8 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        start_xfer(32'h010, 2);
        chk("t1 busy", 64'(busy), 64'd1);
        for (int i = 0; i < 8; i++) begin
            put_byte(bytes8[i], 1'b0);
            if (i == 3) chk("t1 write latency", 64'(sram_write), 64'd1);
        end
        wait_done("t1");
        check_xfer("t1", 2);
        chk("t1 word0", 64'(got_q.size() > 0 ? got_q[0] : '0),
            64'(wr_t'{a: 10'h010, be: 4'hF, d: 32'h44332211}));
        chk("t1 word1", 64'(got_q.size() > 1 ? got_q[1] : '0),
            64'(wr_t'{a: 10'h011, be: 4'hF, d: 32'h88776655}));

        // address wrap from 0x3FF
        start_xfer(32'h3FF, 2);
        for (int i = 0; i < 8; i++) put_byte(8'($urandom), 1'b0);
        wait_done("t2");
        check_xfer("t2", 2);
        chk("t2 wrap addr", 64'(got_q.size() > 1 ? got_q[1].a : '1), 64'h0);

        // partial flush, ignored empty flush, flush with a byte
        start_xfer(32'h020, 4);
        put_byte(8'hAA, 1'b0);
        put_byte(8'hBB, 1'b0);
        flush_only();
        repeat (3) @(negedge clk);
        chk("t3 flush word", 64'(got_q.size() > 0 ? got_q[0] : '0),
            64'(wr_t'{a: 10'h020, be: 4'h3, d: 32'h0000BBAA}));
        chk("t3 busy", 64'(busy), 64'd1);
        chk("t3 ww", 64'(words_written), 64'd1);
        flush_only();
        repeat (3) @(negedge clk);
        chk("t3 empty flush", 64'(got_q.size()), 64'd1);
        put_byte(8'hCC, 1'b1);
        while (m_cnt < m_len) put_byte(8'($urandom), 1'b0);
        wait_done("t3");
        check_xfer("t3", 4);

        // zero length start
        start_xfer(32'h055, 0);
        wait_done("t4");
        chk("t4 no write", 64'(got_q.size()), 64'd0);
        chk("t4 ww", 64'(words_written), 64'd0);

        // start during FILL is ignored
        start_xfer(32'h100, 1);
        put_byte(8'h01, 1'b0);
        put_byte(8'h02, 1'b0);
        @(negedge clk);
        start = 1'b1;
        cfg_base = 10'h200;
        cfg_len = 11'd3;
        @(negedge clk);
        start = 1'b0;
        put_byte(8'h03, 1'b0);
        put_byte(8'h04, 1'b0);
        wait_done("t5");
        check_xfer("t5", 1);

        // in_valid toggling every other cycle, len 1
        start_xfer(32'h0F0, 1);
        for (int i = 0; i < 4; i++) begin
            put_byte(8'($urandom), 1'b0);
            if (i == 3) begin
                chk("t6 write now", 64'(sram_write), 64'd1);
                chk("t6 ready in write", 64'(in_ready), 64'd0);
            end else begin
                @(negedge clk);
            end
        end
        wait_done("t6");
        check_xfer("t6", 1);

        // reset mid-transfer after three bytes
        start_xfer(32'h123, 3);
        for (int i = 0; i < 3; i++) put_byte(8'($urandom), 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_state("t7 rst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk("t7 no write", 64'(got_q.size()), 64'd0);
        start_xfer(32'h2A0, 1);
        for (int i = 0; i < 4; i++) put_byte(8'h10 + 8'(i), 1'b0);
        wait_done("t7");
        check_xfer("t7", 1);

        // length clamp to full address space
        start_xfer(32'($urandom_range(0, (1 << AW) - 1)), (1 << AW) + 5);
        while (m_cnt < m_len) put_byte(8'($urandom), 1'b0);
        wait_done("t8");
        check_xfer("t8", 1 << AW);

        // random transfers with random flushes and gaps
        for (int t = 0; t < 8; t++) begin
            start_xfer(32'($urandom_range(0, (1 << AW) - 1)), $urandom_range(1, 6));
            while (m_cnt < m_len) begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r < 2 && m_pend.size() > 0) flush_only();
                else put_byte(8'($urandom), r == 2);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            wait_done($sformatf("rnd%0d", t));
            check_xfer($sformatf("rnd%0d", t), m_len);
        end

        chk("bus rule violations", 64'(viol), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_sram_writer.md
STREAM_SRAM_WRITER -- requirements
Module: stream_sram_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the SRAM word-address width (1024 x 32-bit words).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: single-cycle pulse that begins a transfer.
REQ-005 SHALL have port cfg_base, input, ADDR_W bits: first word address, sampled on start.
REQ-006 SHALL have port cfg_len, input, ADDR_W+1 bits: transfer length in words, sampled on start.
REQ-007 SHALL have port flush, input, 1 bit: pulse that commits a partially filled word.
REQ-008 SHALL have port in_data, input, 8 bits: byte-stream data, for example from the UART receiver.
REQ-009 SHALL have port in_valid, input, 1 bit: byte-stream valid.
REQ-010 SHALL have port in_ready, output, 1 bit: byte-stream ready.
REQ-011 SHALL have port sram_address, output, ADDR_W bits: word address to the SRAM second port.
REQ-012 SHALL have port sram_byteenable, output, 4 bits: byte lanes to write.
REQ-013 SHALL have port sram_chipselect, output, 1 bit: SRAM select.
REQ-014 SHALL have port sram_write, output, 1 bit: SRAM write strobe.
REQ-015 SHALL have port sram_writedata, output, 32 bits: SRAM write data.
REQ-016 SHALL have port sram_clken, output, 1 bit: SRAM clock enable, held at 1.
REQ-017 SHALL have port busy, output, 1 bit: high when state is not IDLE.
REQ-018 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-019 SHALL have port words_written, output, ADDR_W+1 bits: count of words committed in the current or last transfer.

Function
REQ-020 SHALL implement the states IDLE, FILL, WRITE and DONE.
REQ-021 IDLE: start with cfg_len != 0 SHALL latch base and length, clear words_written and the lane index, and go to FILL.
REQ-022 IDLE: start with cfg_len == 0 SHALL go to DONE without any SRAM write.
REQ-023 IDLE: start with cfg_len > 2^ADDR_W SHALL clamp the length to 2^ADDR_W.
REQ-024 in_ready SHALL be 1 only in FILL; a byte transfers on the cycle in_valid and in_ready are both 1.
REQ-025 Byte k of the current word (k = 0..3, little-endian) SHALL be stored into bits [8k+7:8k], and its lane-enable bit set.
REQ-026 FILL SHALL go to WRITE on the cycle the fourth byte is accepted.
REQ-027 FILL SHALL go to WRITE on flush when at least one lane is filled; flush with zero lanes filled SHALL be ignored.
REQ-028 When flush and a byte transfer occur in the same cycle, that byte SHALL be included in the flushed word.
REQ-029 WRITE SHALL last exactly one cycle, with sram_chipselect = sram_write = 1, sram_address = (base + words_written) mod 2^ADDR_W, sram_byteenable = filled lanes, and sram_writedata = the packed word with unfilled lanes 0.
REQ-030 Address arithmetic SHALL wrap modulo 2^ADDR_W, so that base 0x3FF followed by the next word addresses 0x000.
REQ-031 After WRITE, words_written SHALL increment and the lanes SHALL clear; the state then goes to DONE if words_written equals the length, otherwise back to FILL.
REQ-032 DONE SHALL assert done for exactly one cycle and then go to IDLE.
REQ-033 A start received in any state other than IDLE SHALL be ignored.
REQ-034 Outside WRITE, sram_chipselect, sram_write and sram_byteenable SHALL be 0.
REQ-035 Latency from the last byte accepted to the SRAM write SHALL be 1 cycle, and from the final write to done SHALL be 1 cycle.

Reset
REQ-036 Asserting reset_n low SHALL, asynchronously, set state to IDLE and set in_ready, busy, done, sram_chipselect, sram_write, sram_byteenable, sram_address, sram_writedata and words_written to 0, with sram_clken = 1.
REQ-037 Reset mid-transfer SHALL discard any partial word, with no write issued.

Verification
REQ-038 Test: base = 0x010, len = 2, bytes 11 22 33 44 55 66 77 88 -> writes 0x44332211 @ 0x010 with BE = F, then 0x88776655 @ 0x011 with BE = F; done 1 cycle after the second write; words_written = 2.
REQ-039 Test: base = 0x3FF, len = 2, 8 bytes -> the second write goes to address 0x000.
REQ-040 Test: len = 4, bytes AA BB, then flush -> write 0x0000BBAA with BE = 3; busy remains 1; words_written = 1.
REQ-041 Test: len = 0 start -> done pulses with no write; a start during FILL is ignored and the latched base is unchanged.
REQ-042 Test: in_valid toggling every other cycle with len = 1 -> exactly one write with the correct packing; in_ready = 0 during WRITE.
REQ-043 Test: reset_n low after 3 bytes -> all outputs reach reset values immediately, with no write; a subsequent transfer starts with lane 0.
